// File: rtl/dht_req_scheduler.sv
// Scheduling layer between the UART command path and the DHT11 driver:
// decodes one-byte commands, paces sensor reads and returns two-byte responses.
module dht_req_scheduler #(
  parameter int MIN_INTERVAL_CYC = 100000000,
  parameter int TIMEOUT_CYC      = 5000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  input  logic [7:0]  cmd_code,
  output logic        sens_start,
  input  logic [31:0] sens_data,
  input  logic        sens_done,
  input  logic        sens_error,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_busy,
  input  logic        tx_done,
  output logic        busy,
  output logic        cmd_drop,
  output logic [2:0]  state
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] WAIT_GAP = 3'd1;
  localparam logic [2:0] READ     = 3'd2;
  localparam logic [2:0] SEND0    = 3'd3;
  localparam logic [2:0] WAIT0    = 3'd4;
  localparam logic [2:0] SEND1    = 3'd5;
  localparam logic [2:0] WAIT1    = 3'd6;

  localparam int GW = $clog2(MIN_INTERVAL_CYC + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [GW-1:0] GAP_MAX = GW'(MIN_INTERVAL_CYC);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

  logic [2:0]    stateReg, stateNext;
  logic [GW-1:0] gapCnt;
  logic [TW-1:0] toCnt;
  logic          cacheValid, lastErr, cmdDropReg;
  logic [7:0]    cacheTemp, cacheHum, cmdReg;
  logic [7:0]    rspByte0, rspByte1, hitByte0, hitByte1;
  logic          gapOk, isSensCmd, readFail;
  logic          unusedSensBits;

  assign gapOk     = (gapCnt == GAP_MAX);
  assign isSensCmd = (cmd_code == 8'h01) || (cmd_code == 8'h02);
  // The last allowed READ cycle is the one where toCnt hits TIMEOUT_CYC-1.
  assign readFail  = sens_error || (toCnt == TO_LAST);
  assign unusedSensBits = ^{sens_data[23:16], sens_data[7:0]};

  // Response for a command answered straight from IDLE (cache hit, status, unknown).
  always_comb begin
    hitByte0 = 8'hEF;
    hitByte1 = cmd_code;
    case (cmd_code)
      8'h01: begin hitByte0 = 8'h1D; hitByte1 = cacheTemp; end
      8'h02: begin hitByte0 = 8'h2D; hitByte1 = cacheHum; end
      8'h03: begin hitByte0 = 8'h0D; hitByte1 = {cacheValid, lastErr, 6'b0}; end
      default: ;
    endcase
  end

  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      IDLE: if (cmd_valid) begin
        if (!isSensCmd)      stateNext = SEND0;
        else if (gapOk)      stateNext = READ;
        else if (cacheValid) stateNext = SEND0;
        else                 stateNext = WAIT_GAP;
      end
      WAIT_GAP: if (gapOk) stateNext = READ;
      READ:     if (sens_done || readFail) stateNext = SEND0;
      SEND0:    if (!tx_busy) stateNext = WAIT0;
      WAIT0:    if (tx_done) stateNext = SEND1;
      SEND1:    if (!tx_busy) stateNext = WAIT1;
      WAIT1:    if (tx_done) stateNext = IDLE;
      default:  stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateReg   <= IDLE;
      gapCnt     <= GAP_MAX;
      toCnt      <= '0;
      cacheValid <= 1'b0;
      lastErr    <= 1'b0;
      cacheTemp  <= 8'h00;
      cacheHum   <= 8'h00;
      cmdReg     <= 8'h00;
      rspByte0   <= 8'h00;
      rspByte1   <= 8'h00;
      cmdDropReg <= 1'b0;
    end else begin
      stateReg   <= stateNext;
      cmdDropReg <= cmd_valid && (stateReg != IDLE);
      if (stateNext == READ && stateReg != READ)
        gapCnt <= '0;
      else if (!gapOk)
        gapCnt <= gapCnt + 1'b1;
      toCnt <= (stateReg == READ) ? toCnt + 1'b1 : '0;
      if (stateReg == IDLE && cmd_valid) begin
        cmdReg   <= cmd_code;
        rspByte0 <= hitByte0;
        rspByte1 <= hitByte1;
      end
      // Simultaneous done and error is treated as an error.
      if (stateReg == READ) begin
        if (readFail) begin
          cacheValid <= 1'b0;
          lastErr    <= 1'b1;
          rspByte0   <= 8'hE0;
          rspByte1   <= 8'h00;
        end else if (sens_done) begin
          cacheTemp  <= sens_data[15:8];
          cacheHum   <= sens_data[31:24];
          cacheValid <= 1'b1;
          lastErr    <= 1'b0;
          rspByte0   <= (cmdReg == 8'h01) ? 8'h1D : 8'h2D;
          rspByte1   <= (cmdReg == 8'h01) ? sens_data[15:8] : sens_data[31:24];
        end
      end
    end
  end

  assign state      = stateReg;
  assign busy       = (stateReg != IDLE);
  assign sens_start = (stateReg == READ);
  assign cmd_drop   = cmdDropReg;
  assign tx_start   = ((stateReg == SEND0) || (stateReg == SEND1)) && !tx_busy;
  assign tx_data    = ((stateReg == SEND0) || (stateReg == WAIT0)) ? rspByte0 :
                      ((stateReg == SEND1) || (stateReg == WAIT1)) ? rspByte1 : 8'h00;

endmodule

// File: tb/tb_dht_req_scheduler.sv
// Table-driven bench for dht_req_scheduler with small sensor and UART responders.
module tb_dht_req_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic [7:0]  cmd_code;
  logic        sens_start;
  logic [31:0] sens_data;
  logic        sens_done;
  logic        sens_error;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic        tx_done;
  logic        busy;
  logic        cmd_drop;
  logic [2:0]  state;

  always #5 clk = ~clk;

  dht_req_scheduler #(.MIN_INTERVAL_CYC(1000), .TIMEOUT_CYC(500)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_code(cmd_code),
    .sens_start(sens_start), .sens_data(sens_data), .sens_done(sens_done),
    .sens_error(sens_error), .tx_data(tx_data), .tx_start(tx_start),
    .tx_busy(tx_busy), .tx_done(tx_done), .busy(busy), .cmd_drop(cmd_drop),
    .state(state)
  );

  // mode: 0 no read expected, 1 done, 2 error, 3 silent sensor, 4 done+error
  typedef struct {
    logic [7:0]  code;
    int          mode;
    int          dly;
    logic [31:0] data;
    int          preWait;
    int          hold;
    int          dropAt;
    logic [7:0]  e0;
    logic [7:0]  e1;
    int          eRead;
    int          eLat;
    int          eDrop;
    int          eGap;
  } vec_t;

  vec_t vecs[11];
  int testsRun = 0;
  int testsFailed = 0;

  // sens_start rise history, measured in negedges
  int cyc = 0;
  int lastRise = -1;
  int prevRise = -1;
  logic prevSs = 1'b0;
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      lastRise = -1;
      prevRise = -1;
      prevSs   = 1'b0;
    end else begin
      if (sens_start && !prevSs) begin
        prevRise = lastRise;
        lastRise = cyc;
      end
      prevSs = sens_start;
    end
  end

  logic [7:0] gotB [2];
  int rc, startLat, drops, extraTx, nBytes;
  logic finOk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic runCmd(input logic [7:0] code, input int mode, input int dly,
                        input logic [31:0] data, input int hold, input int dropAt);
    int lat, dt;
    logic fin;
    cmd_code  = code;
    cmd_valid = 1'b1;
    tx_busy   = (hold > 0);
    tick();
    cmd_valid = 1'b0;
    lat = 1; rc = 0; nBytes = 0; dt = -1; drops = 0; fin = 1'b0;
    finOk = 1'b0; startLat = -1; gotB[0] = 8'h00; gotB[1] = 8'h00;
    for (int g = 0; g < 3000; g++) begin
      tx_busy = (lat <= hold);
      #1;
      sens_done = 1'b0; sens_error = 1'b0; tx_done = 1'b0; cmd_valid = 1'b0;
      if (fin) begin
        finOk = !busy && (state == 3'd0);
        break;
      end
      if (cmd_drop) drops++;
      if (sens_start) begin
        rc++;
        if (rc == dly) begin
          case (mode)
            1: begin sens_done = 1'b1; sens_data = data; end
            2: sens_error = 1'b1;
            4: begin sens_done = 1'b1; sens_error = 1'b1; sens_data = data; end
            default: ;
          endcase
        end
      end
      if (tx_start) begin
        if (nBytes == 0) startLat = lat;
        if (nBytes < 2) gotB[nBytes] = tx_data;
        nBytes++;
        dt = 3;
      end else if (dt > 0) begin
        dt--;
        if (dt == 0) begin
          tx_done = 1'b1;
          dt = -1;
          if (nBytes == 2) fin = 1'b1;
        end
      end
      if (lat == dropAt) begin
        cmd_valid = 1'b1;
        cmd_code  = 8'h01;
      end
      tick();
      lat++;
    end
    tx_busy = 1'b0;
    extraTx = 0;
    repeat (5) begin
      tick();
      #1;
      if (tx_start || state != 3'd0) extraTx++;
    end
  endtask

  initial begin
    vecs[0]  = '{8'h01, 1, 200, 32'h3700_1A05,    0,  0, 0, 8'h1D, 8'h1A, 200, 201, 0,   -1};
    vecs[1]  = '{8'h02, 0,   0, 32'h0,          100,  0, 0, 8'h2D, 8'h37,   0,   1, 0,   -1};
    vecs[2]  = '{8'h03, 0,   0, 32'h0,            0,  0, 0, 8'h0D, 8'h80,   0,   1, 0,   -1};
    vecs[3]  = '{8'h01, 2,  50, 32'h0,         1000,  0, 0, 8'hE0, 8'h00,  50,  51, 0,   -1};
    vecs[4]  = '{8'h01, 1,  10, 32'h1122_3344,    0,  0, 0, 8'h1D, 8'h33,  10,  -1, 0, 1001};
    vecs[5]  = '{8'h02, 0,   0, 32'h0,            0,  0, 0, 8'h2D, 8'h11,   0,   1, 0,   -1};
    vecs[6]  = '{8'h01, 3,   0, 32'h0,         1000,  0, 0, 8'hE0, 8'h00, 500, 501, 0,   -1};
    vecs[7]  = '{8'h03, 0,   0, 32'h0,            0,  0, 0, 8'h0D, 8'h40,   0,   1, 0,   -1};
    vecs[8]  = '{8'h55, 0,   0, 32'h0,            0,  0, 3, 8'hEF, 8'h55,   0,   1, 1,   -1};
    vecs[9]  = '{8'hA7, 0,   0, 32'h0,            0, 50, 0, 8'hEF, 8'hA7,   0,  51, 0,   -1};
    vecs[10] = '{8'h02, 4,  20, 32'h6600_7700, 1000,  0, 0, 8'hE0, 8'h00,  20,  21, 0,   -1};

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_code = 8'h00; sens_data = 32'h0;
    sens_done = 1'b0; sens_error = 1'b0; tx_busy = 1'b0; tx_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset outputs", {sens_start, tx_data, tx_start, busy, cmd_drop, state}, 64'h0);
    rst_n = 1'b1;
    tick();
    check("idle after reset", {busy, state}, 64'h0);

    for (int i = 0; i < 11; i++) begin
      repeat (vecs[i].preWait) tick();
      runCmd(vecs[i].code, vecs[i].mode, vecs[i].dly, vecs[i].data, vecs[i].hold, vecs[i].dropAt);
      $display("[TB] vec %0d cmd=%02h bytes=%02h %02h read=%0d lat=%0d drops=%0d",
               i, vecs[i].code, gotB[0], gotB[1], rc, startLat, drops);
      check($sformatf("v%0d byte0", i), gotB[0], vecs[i].e0);
      check($sformatf("v%0d byte1", i), gotB[1], vecs[i].e1);
      check($sformatf("v%0d read cycles", i), rc, vecs[i].eRead);
      check($sformatf("v%0d busy low at end", i), finOk, 1'b1);
      check($sformatf("v%0d extra tx", i), extraTx, 0);
      check($sformatf("v%0d cmd_drop pulses", i), drops, vecs[i].eDrop);
      if (vecs[i].eLat >= 0)
        check($sformatf("v%0d tx_start latency", i), startLat, vecs[i].eLat);
      if (vecs[i].eGap >= 0)
        check($sformatf("v%0d read spacing", i), lastRise - prevRise, vecs[i].eGap);
    end

    // Reset while reading; reset must saturate the gap so the next read starts at once.
    repeat (1000) tick();
    cmd_code = 8'h01;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    repeat (10) tick();
    check("in READ before reset", {state, sens_start}, {3'd2, 1'b1});
    rst_n = 1'b0;
    #1;
    check("async reset outputs", {sens_start, tx_data, tx_start, busy, cmd_drop, state}, 64'h0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    runCmd(8'h01, 1, 5, 32'h2A00_1500, 0, 0);
    $display("[TB] post-reset cmd=01 bytes=%02h %02h read=%0d lat=%0d", gotB[0], gotB[1], rc, startLat);
    check("post-reset byte0", gotB[0], 8'h1D);
    check("post-reset byte1", gotB[1], 8'h15);
    check("post-reset read cycles", rc, 5);
    check("post-reset latency", startLat, 6);
    check("post-reset busy low", finOk, 1'b1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
